// File: rtl/cond_logic_mc.sv
// Condition-check stage behind the multicycle control FSM: NZCV flags,
// condition evaluation, write-enable gating and retire/squash counters.
module cond_logic_mc #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               IRWrite,
    input  logic               CountClr,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [3:0]         Flags,
    output logic [COUNT_W-1:0] RetireCount,
    output logic [COUNT_W-1:0] SquashCount
);

    logic       cond_ex;
    logic       cond_ex_d;
    logic       decode_cyc;
    logic       exec_tag;
    logic       in_flight;
    logic [1:0] flag_write;
    logic       n, z, c, v;

    assign n = Flags[3];
    assign z = Flags[2];
    assign c = Flags[1];
    assign v = Flags[0];

    always_comb begin
        cond_ex = 1'b1;
        unique case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c && !z;
            4'b1001: cond_ex = !c || z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = !z && (n == v);
            4'b1101: cond_ex = z || (n != v);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b1;
        endcase
    end

    assign flag_write = FlagW & {2{cond_ex}};

    // NextPC is the FETCH increment and is never suppressed.
    assign PCWrite  = (PCS & cond_ex_d) | NextPC;
    assign RegWrite = RegW & cond_ex_d;
    assign MemWrite = MemW & cond_ex_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags      <= '0;
            cond_ex_d  <= 1'b0;
            decode_cyc <= 1'b0;
            exec_tag   <= 1'b0;
            in_flight  <= 1'b0;
        end else begin
            if (flag_write[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flag_write[0]) Flags[1:0] <= ALUFlags[1:0];
            cond_ex_d  <= cond_ex;
            decode_cyc <= IRWrite;
            if (decode_cyc) exec_tag <= cond_ex;
            if (IRWrite) in_flight <= 1'b1;
        end
    end

    // An IRWrite closes the previous instruction, tagged in its DECODE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RetireCount <= '0;
            SquashCount <= '0;
        end else if (CountClr) begin
            RetireCount <= '0;
            SquashCount <= '0;
        end else if (IRWrite && in_flight) begin
            if (exec_tag) RetireCount <= RetireCount + 1'b1;
            else          SquashCount <= SquashCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_logic_mc.sv
// Randomized scoreboard bench for cond_logic_mc against an instruction-level
// reference model of ARM condition evaluation and retire accounting.
module tb_cond_logic_mc;

    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    Cond, ALUFlags;
    logic [1:0]    FlagW;
    logic          PCS, NextPC, RegW, MemW, IRWrite, CountClr;
    logic          PCWrite, RegWrite, MemWrite;
    logic [3:0]    Flags;
    logic [CW-1:0] RetireCount, SquashCount;

    cond_logic_mc #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .IRWrite(IRWrite), .CountClr(CountClr),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .RetireCount(RetireCount), .SquashCount(SquashCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pcw;
        logic          rw;
        logic          mw;
        logic [3:0]    fl;
        logic [CW-1:0] ret;
        logic [CW-1:0] sq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference state: architectural flags and instruction bookkeeping.
    bit m_n, m_z, m_c, m_v;
    bit m_gate;
    bit m_decode, m_pass, m_started;
    int m_ret, m_sq;

    // ARM rule: pairs of conditions share a base test; odd codes invert it.
    function automatic bit passes(input logic [3:0] cd);
        bit base;
        if (cd[3:1] == 3'b111) return 1'b1;
        case (cd[3:1])
            3'd0: base = m_z;
            3'd1: base = m_c;
            3'd2: base = m_n;
            3'd3: base = m_v;
            3'd4: base = m_c && !m_z;
            3'd5: base = (m_n == m_v);
            default: base = !m_z && (m_n == m_v);
        endcase
        return cd[0] ? !base : base;
    endfunction

    task automatic model_reset();
        {m_n, m_z, m_c, m_v} = 4'b0;
        m_gate = 0; m_decode = 0; m_pass = 0; m_started = 0;
        m_ret = 0; m_sq = 0;
    endtask

    task automatic model_step();
        bit ce;
        exp_t e;
        if (!reset) model_reset();
        e.pcw = (PCS && m_gate) || NextPC;
        e.rw  = RegW && m_gate;
        e.mw  = MemW && m_gate;
        e.fl  = {m_n, m_z, m_c, m_v};
        e.ret = CW'(m_ret);
        e.sq  = CW'(m_sq);
        exp_q.push_back(e);
        if (!reset) return;
        ce = passes(Cond);
        if (CountClr) begin
            m_ret = 0; m_sq = 0;
        end else if (IRWrite && m_started) begin
            if (m_pass) m_ret = (m_ret + 1) % MOD;
            else        m_sq  = (m_sq + 1) % MOD;
        end
        if (m_decode) m_pass = ce;
        m_decode = IRWrite;
        if (IRWrite) m_started = 1;
        m_gate = ce;
        if (ce && FlagW[1]) {m_n, m_z} = ALUFlags[3:2];
        if (ce && FlagW[0]) {m_c, m_v} = ALUFlags[1:0];
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{PCWrite, RegWrite, MemWrite, Flags,
                      RetireCount, SquashCount};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cyc%0d outs: got pcw=%b rw=%b mw=%b fl=%b ret=%0d sq=%0d want pcw=%b rw=%b mw=%b fl=%b ret=%0d sq=%0d",
                             checks, a.pcw, a.rw, a.mw, a.fl, a.ret, a.sq,
                             e.pcw, e.rw, e.mw, e.fl, e.ret, e.sq);
                end
            end
        end
    end

    task automatic drive_idle();
        Cond = 4'he; ALUFlags = 0; FlagW = 0; PCS = 0; NextPC = 0;
        RegW = 0; MemW = 0; IRWrite = 0; CountClr = 0;
    endtask

    initial begin : stim
        int gap;
        int phase;
        int rst_left;
        logic [3:0] icond;
        reset = 1'b0;
        drive_idle();
        model_reset();
        gap = 2; phase = 0; rst_left = 0; icond = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            model_step();
        end
        @(negedge clk);
        reset = 1'b1;
        Cond = 4'h0; RegW = 1'b1;
        model_step();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drive_idle();
            if (rst_left > 0) rst_left--;
            reset = (rst_left == 0);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
            if (gap == 0) begin
                IRWrite = 1'b1;
                gap = $urandom_range(3, 4);
                phase = 0;
                icond = $urandom_range(0, 3) == 0 ? 4'he : 4'($urandom);
            end else begin
                gap--;
                phase++;
            end
            NextPC   = (phase == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            Cond     = icond;
            ALUFlags = 4'($urandom);
            FlagW    = (phase >= 2) ? 2'($urandom) : 2'b00;
            PCS      = 1'($urandom);
            RegW     = (phase >= 2) ? 1'($urandom) : 1'b0;
            MemW     = (phase >= 2) ? 1'($urandom) : 1'b0;
            CountClr = ($urandom_range(0, 63) == 0);
            model_step();
        end
        done = 1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
